// File: rtl/shift_lr_pipe.sv
// Pipelined bi-directional barrel shifter (SRA/SRL/SLL/ROL) with valid/ready on both sides.
// Optional ZERO/CARRY flag outputs are built only when SHIFT_FLAGS_EN is defined.
module shift_lr_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SHW    = $clog2(WIDTH),
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [SHW-1:0]   S,
    input  logic [1:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT_FLAGS_EN
    output logic             ZERO,
    output logic             CARRY,
`endif
    output logic [WIDTH-1:0] Z
);

    localparam int unsigned GRP = (SHW + STAGES - 1) / STAGES;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic stall;

    // A stalled output freezes every stage, bubbles included.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int unsigned LO = g * GRP;
        localparam int unsigned HI = ((g + 1) * GRP < SHW) ? (g + 1) * GRP : SHW;

        logic [WIDTH-1:0] d_in;
        logic [SHW-1:0]   sh_in;
        logic [1:0]       op_in;
        logic             v_in;
        logic [WIDTH-1:0] d_out;
        logic [WIDTH-1:0] data_q;
        logic             vld_q;
`ifdef SHIFT_FLAGS_EN
        logic             c_in;
        logic             c_out;
        logic             cry_q;
`endif

        if (g == 0) begin : g_src
            assign d_in  = X;
            assign sh_in = S;
            assign op_in = OP;
            assign v_in  = in_valid;
`ifdef SHIFT_FLAGS_EN
            assign c_in  = 1'b0;
`endif
        end else begin : g_chain
            assign d_in  = g_stage[g-1].data_q;
            assign sh_in = g_stage[g-1].g_fwd.sh_q;
            assign op_in = g_stage[g-1].g_fwd.op_q;
            assign v_in  = g_stage[g-1].vld_q;
`ifdef SHIFT_FLAGS_EN
            assign c_in  = g_stage[g-1].cry_q;
`endif
        end

        // Mux levels owned by this stage; level j shifts by 2^(SHW-1-j).
        always_comb begin : level_mux
            logic [WIDTH-1:0] d;
            logic             sb;
            int unsigned      amt;
`ifdef SHIFT_FLAGS_EN
            logic             c;
            c = c_in;
`endif
            d   = d_in;
            sb  = 1'b0;
            amt = 0;
            for (int unsigned j = LO; j < HI; j++) begin
                sb  = 1'(sh_in >> (SHW - 1 - j));
                amt = 1 << (SHW - 1 - j);
                if (sb) begin
                    case (op_in)
                        OP_SRA: begin
`ifdef SHIFT_FLAGS_EN
                            c = 1'(d >> (amt - 1));
`endif
                            d = WIDTH'($signed(d) >>> amt);
                        end
                        OP_SRL: begin
`ifdef SHIFT_FLAGS_EN
                            c = 1'(d >> (amt - 1));
`endif
                            d = d >> amt;
                        end
                        OP_SLL: begin
`ifdef SHIFT_FLAGS_EN
                            c = 1'(d >> (WIDTH - amt));
`endif
                            d = d << amt;
                        end
                        OP_ROL: begin
                            d = (d << amt) | (d >> (WIDTH - amt));
`ifdef SHIFT_FLAGS_EN
                            c = d[0];
`endif
                        end
                        default: d = d_in;
                    endcase
                end
            end
            d_out = d;
`ifdef SHIFT_FLAGS_EN
            c_out = c;
`endif
        end

        // Payload loads only for a valid op, so Z changes only when a result arrives.
        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q  <= 1'b0;
                data_q <= '0;
`ifdef SHIFT_FLAGS_EN
                cry_q  <= 1'b0;
`endif
            end else if (!stall) begin
                vld_q <= v_in;
                if (v_in) begin
                    data_q <= d_out;
`ifdef SHIFT_FLAGS_EN
                    cry_q  <= c_out;
`endif
                end
            end
        end

        if (g < STAGES - 1) begin : g_fwd
            logic [SHW-1:0] sh_q;
            logic [1:0]     op_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    sh_q <= '0;
                    op_q <= '0;
                end else if (!stall && v_in) begin
                    sh_q <= sh_in;
                    op_q <= op_in;
                end
            end
        end

`ifdef SHIFT_FLAGS_EN
        if (g == STAGES - 1) begin : g_out
            logic zero_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    zero_q <= 1'b0;
                end else if (!stall && v_in) begin
                    zero_q <= (d_out == '0);
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign Z         = g_stage[STAGES-1].data_q;
`ifdef SHIFT_FLAGS_EN
    assign ZERO      = g_stage[STAGES-1].g_out.zero_q;
    assign CARRY     = g_stage[STAGES-1].cry_q;
`endif

endmodule

// File: tb/tb_shift_lr_pipe.sv
// Scoreboard bench for shift_lr_pipe (WIDTH=32, STAGES=2); checks flags when SHIFT_FLAGS_EN is defined.
module tb_shift_lr_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  X;
    logic [SW-1:0] S;
    logic [1:0]    OP;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Z;
`ifdef SHIFT_FLAGS_EN
    logic          ZERO;
    logic          CARRY;
`endif

    typedef struct {
        logic [W-1:0] z;
        logic         zero;
        logic         carry;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_z     = '0;
    bit           rand_done  = 1'b0;

    shift_lr_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .S         (S),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHIFT_FLAGS_EN
        .ZERO      (ZERO),
        .CARRY     (CARRY),
`endif
        .Z         (Z)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain shift/rotate arithmetic; CARRY taken straight from the operand bits.
    function automatic exp_t model(input logic [W-1:0] x, input logic [SW-1:0] s, input logic [1:0] op);
        exp_t        e;
        logic [63:0] dbl;
        dbl = {x, x} << s;
        case (op)
            2'b00:   e.z = W'($signed(x) >>> s);
            2'b01:   e.z = x >> s;
            2'b10:   e.z = x << s;
            default: e.z = dbl[63:32];
        endcase
        if (s == '0)         e.carry = 1'b0;
        else if (op == 2'b10) e.carry = 1'(x >> (6'd32 - 6'(s)));
        else if (op == 2'b11) e.carry = e.z[0];
        else                  e.carry = 1'(x >> (s - 5'd1));
        e.zero = (e.z == '0);
        e.cyc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    function automatic exp_t konst(input logic [W-1:0] z, input logic zero, input logic carry);
        exp_t e;
        e.z = z; e.zero = zero; e.carry = carry; e.cyc = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Holds the op until accepted; the expectation is queued on the accepting cycle.
    task automatic send(input logic [W-1:0] x, input logic [SW-1:0] s, input logic [1:0] op,
                        input exp_t e_in, input bit lat);
        exp_t e;
        bit   acc;
        int   n;
        e = e_in; acc = 1'b0; n = 0;
        in_valid = 1'b1; X = x; S = s; OP = op;
        while (!acc && n < 500) begin
            @(negedge clock);
            acc = in_ready;
            if (acc) begin
                e.cyc = cyc;
                e.lat = lat;
                exp_q.push_back(e);
            end
            @(posedge clock);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout op=%0d x=%h s=%0d never accepted", op, x, s);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("drain_pending", W'(exp_q.size()), '0);
    endtask

    // Output monitor: pops and compares on every delivery, and checks the stall/hold rules.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_z", Z, prev_z);
            end
            chk1("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", Z);
                end else begin
                    e = exp_q.pop_front();
                    chk("z", Z, e.z);
`ifdef SHIFT_FLAGS_EN
                    chk1("zero", ZERO, e.zero);
                    chk1("carry", CARRY, e.carry);
`endif
                    if (e.lat) chk("latency", W'(cyc - e.cyc), 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_z     = Z;
        end
    end

    initial begin
        logic [W-1:0] x;
        reset = 1'b1; in_valid = 1'b0; X = '0; S = '0; OP = '0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_z", Z, '0);
        chk1("reset_in_ready", in_ready, 1'b1);
`ifdef SHIFT_FLAGS_EN
        chk1("reset_zero", ZERO, 1'b0);
        chk1("reset_carry", CARRY, 1'b0);
`endif

        // Directed boundary cases with hand-derived results.
        send(32'h8000_0000, 5'd31, 2'b00, konst(32'hFFFF_FFFF, 1'b0, 1'b0), 1'b1);
        idle(3);
        send(32'h8000_0000, 5'd31, 2'b01, konst(32'h0000_0001, 1'b0, 1'b0), 1'b1);
        send(32'h0000_0001, 5'd31, 2'b10, konst(32'h8000_0000, 1'b0, 1'b0), 1'b1);
        send(32'h8000_0001, 5'd4,  2'b11, konst(32'h0000_0018, 1'b0, 1'b0), 1'b1);
        send(32'h8000_0001, 5'd0,  2'b11, konst(32'h8000_0001, 1'b0, 1'b0), 1'b1);
`ifdef SHIFT_FLAGS_EN
        send(32'h8000_0000, 5'd1, 2'b10, konst(32'h0000_0000, 1'b1, 1'b1), 1'b1);
        send(32'h0000_0002, 5'd1, 2'b01, konst(32'h0000_0001, 1'b0, 1'b0), 1'b1);
`endif
        idle(4);

        // Full S sweep, every op, back-to-back with no stalls.
        for (int s = 0; s < 32; s++) begin
            for (int o = 0; o < 4; o++) begin
                x = $urandom();
                send(x, SW'(s), 2'(o), model(x, SW'(s), 2'(o)), 1'b1);
            end
        end
        drain();

        // Backpressure: consumer blocks for 5 cycles while 3 ops are offered.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    x = $urandom();
                    send(x, 5'(i + 3), 2'(i), model(x, 5'(i + 3), 2'(i)), 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random ops against a randomly stalling consumer.
        rand_done = 1'b0;
        fork
            begin
                logic [SW-1:0] rs;
                logic [1:0]    ro;
                for (int i = 0; i < 200; i++) begin
                    x  = $urandom();
                    rs = SW'($urandom_range(31));
                    ro = 2'($urandom_range(3));
                    send(x, rs, ro, model(x, rs, ro), 1'b0);
                    if ($urandom_range(4) == 0) idle(1);
                end
                in_valid  = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight: both must vanish.
        out_ready = 1'b0;
        x = $urandom();
        send(x, 5'd7, 2'b01, model(x, 5'd7, 2'b01), 1'b0);
        send(x, 5'd9, 2'b10, model(x, 5'd9, 2'b10), 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk1("midreset_out_valid", out_valid, 1'b0);
        chk("midreset_z", Z, '0);
`ifdef SHIFT_FLAGS_EN
        chk1("midreset_zero", ZERO, 1'b0);
        chk1("midreset_carry", CARRY, 1'b0);
`endif
        reset = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk1("post_reset_quiet", out_valid, 1'b0);

        // Pipeline still works after the flush.
        x = $urandom();
        send(x, 5'd13, 2'b00, model(x, 5'd13, 2'b00), 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
